rs_entry_array: RTL

// Reservation-station storage feeding the issue selector: holds SIZE waiting instructions,

---
 rtl/rs_entry_array.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rs_entry_array.sv
// Reservation-station entry storage: captures dispatched instructions, wakes operands from the CDB,
// exports free/ready vectors to the issue selector and muxes the selected entry out to the FU.
module rs_entry_array #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              flush_i,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  output logic              alloc_fire_o,
  input  logic [OP_W-1:0]   alloc_op_i,
  input  logic [TAG_W-1:0]  alloc_dest_i,
  input  logic              src1_rdy_i,
  input  logic [TAG_W-1:0]  src1_tag_i,
  input  logic [DATA_W-1:0] src1_val_i,
  input  logic              src2_rdy_i,
  input  logic [TAG_W-1:0]  src2_tag_i,
  input  logic [DATA_W-1:0] src2_val_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_val_i,
  output logic [SIZE-1:0]   entry_free_o,
  output logic [SIZE-1:0]   entry_ready_o,
  input  logic [SIZE-1:0]   issue_sel_i,
  input  logic              issue_ready_i,
  output logic              issue_valid_o,
  output logic [OP_W-1:0]   issue_op_o,
  output logic [TAG_W-1:0]  issue_dest_o,
  output logic [DATA_W-1:0] issue_src1_o,
  output logic [DATA_W-1:0] issue_src2_o
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [SIZE-1:0]             valid_q, valid_d;
  logic [SIZE-1:0]             rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [SIZE-1:0][OP_W-1:0]   op_q, op_d;
  logic [SIZE-1:0][TAG_W-1:0]  dest_q, dest_d;
  logic [SIZE-1:0][TAG_W-1:0]  tag1_q, tag1_d, tag2_q, tag2_d;
  logic [SIZE-1:0][DATA_W-1:0] val1_q, val1_d, val2_q, val2_d;

  logic [IDX_W-1:0] allocIdx;
  logic [IDX_W-1:0] selIdx;
  logic             issueFire;
  logic             src1Hit;
  logic             src2Hit;

  // Status outputs come from registered state only, so the selector sees no alloc/CDB comb path.
  assign entry_free_o  = ~valid_q;
  assign entry_ready_o = valid_q & rdy1_q & rdy2_q;
  assign alloc_ready_o = |(~valid_q);
  assign alloc_fire_o  = alloc_valid_i & alloc_ready_o & ~flush_i;
  assign issueFire     = issue_valid_o & issue_ready_i;

  assign src1Hit = ~src1_rdy_i & cdb_valid_i & (cdb_tag_i == src1_tag_i);
  assign src2Hit = ~src2_rdy_i & cdb_valid_i & (cdb_tag_i == src2_tag_i);

  always_comb begin
    allocIdx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) allocIdx = IDX_W'(i);
    end
  end

  always_comb begin
    selIdx = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (issue_sel_i[i]) selIdx = IDX_W'(i);
    end
  end

  always_comb begin
    issue_valid_o = $onehot(issue_sel_i) && entry_ready_o[selIdx];
    issue_op_o    = '0;
    issue_dest_o  = '0;
    issue_src1_o  = '0;
    issue_src2_o  = '0;
    if (issue_valid_o) begin
      issue_op_o   = op_q[selIdx];
      issue_dest_o = dest_q[selIdx];
      issue_src1_o = val1_q[selIdx];
      issue_src2_o = val2_q[selIdx];
    end
  end

  // Wakeup only touches valid entries, and allocation targets a free one, so they never collide.
  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    op_d    = op_q;
    dest_d  = dest_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    val1_d  = val1_q;
    val2_d  = val2_q;

    for (int i = 0; i < SIZE; i++) begin
      if (valid_q[i] && cdb_valid_i) begin
        if (!rdy1_q[i] && (tag1_q[i] == cdb_tag_i)) begin
          rdy1_d[i] = 1'b1;
          val1_d[i] = cdb_val_i;
        end
        if (!rdy2_q[i] && (tag2_q[i] == cdb_tag_i)) begin
          rdy2_d[i] = 1'b1;
          val2_d[i] = cdb_val_i;
        end
      end
    end

    if (issueFire) valid_d[selIdx] = 1'b0;

    if (alloc_fire_o) begin
      valid_d[allocIdx] = 1'b1;
      op_d[allocIdx]    = alloc_op_i;
      dest_d[allocIdx]  = alloc_dest_i;
      tag1_d[allocIdx]  = src1_tag_i;
      tag2_d[allocIdx]  = src2_tag_i;
      rdy1_d[allocIdx]  = src1_rdy_i | src1Hit;
      rdy2_d[allocIdx]  = src2_rdy_i | src2Hit;
      val1_d[allocIdx]  = src1Hit ? cdb_val_i : src1_val_i;
      val2_d[allocIdx]  = src2Hit ? cdb_val_i : src2_val_i;
    end

    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      val1_q  <= '0;
      val2_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      val1_q  <= val1_d;
      val2_q  <= val2_d;
    end
  end

endmodule
